// File: rtl/param_stream_pkg.sv
// Shared state encoding and sizing helpers for the parameter ROM stream controller.
package param_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned ROM_LATENCY_DEF = 2;

    // One slot per in-flight read plus the beat being handed downstream.
    function automatic int unsigned fifo_depth_for(input int unsigned rom_latency);
        return rom_latency + 1;
    endfunction

endpackage

// File: rtl/param_stream_fifo.sv
// Shift-style output FIFO: the head is always entry 0, so data_out comes straight off a flop.
module param_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned FIFO_DEPTH = 3,
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  head_valid,
    output logic [CNT_WIDTH-1:0]  count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  wr_idx;
    logic                  valid_q, valid_d;

    // Pop shifts everything down; a push lands just past the surviving entries.
    always_comb begin
        mem_d   = mem_q;
        wr_idx  = count_q;
        if (pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            wr_idx = count_q - CNT_WIDTH'(1);
        end
        if (push) begin
            mem_d[wr_idx] = push_data;
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        if (flush) begin
            count_d = '0;
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign head       = mem_q[0];
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/param_rom_stream_ctrl.sv
// Streams a fixed-latency parameter ROM as valid/ready beats, replaying it num_passes times
// per start; reads are issued only when the output FIFO is guaranteed room for the return.
module param_rom_stream_ctrl
    import param_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned OUT_DEPTH   = 32,
    parameter int unsigned ROM_LATENCY = ROM_LATENCY_DEF,
    parameter int unsigned FIFO_DEPTH  = fifo_depth_for(ROM_LATENCY),
    parameter int unsigned PASS_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRED_WIDTH = $clog2(ROM_LATENCY + FIFO_DEPTH + 1);

    state_e                 state_q, state_d;
    logic [PASS_WIDTH-1:0]  num_passes_q, num_passes_d;
    logic [PASS_WIDTH-1:0]  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY-1:0] issue_sr_q, issue_sr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   issue, pop, push, flush;
    logic                   addr_last, pass_last;
    logic [CRED_WIDTH-1:0]  inflight;
    logic [CNT_WIDTH-1:0]   fifo_count;
    logic                   fifo_valid;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(ROM_LATENCY); i++) begin
            inflight = inflight + CRED_WIDTH'(issue_sr_q[i]);
        end
    end

    // Credit: every outstanding read plus every buffered beat must fit once this cycle's pop leaves.
    assign pop       = fifo_valid && data_out_ready;
    assign push      = issue_sr_q[ROM_LATENCY-1];
    assign issue     = (state_q == RUN) &&
                       ((inflight + CRED_WIDTH'(fifo_count) - CRED_WIDTH'(pop)) < CRED_WIDTH'(FIFO_DEPTH));
    assign addr_last = (rom_addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));
    assign pass_last = (pass_q == num_passes_q - PASS_WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        num_passes_d = num_passes_q;
        pass_d       = pass_q;
        rom_addr_d   = rom_addr_q;
        issue_sr_d   = ROM_LATENCY'({issue_sr_q, issue});
        flush        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_passes_d = num_passes;
                    pass_d       = '0;
                    rom_addr_d   = '0;
                    state_d      = (num_passes == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    if (addr_last) begin
                        rom_addr_d = '0;
                        pass_d     = pass_q + PASS_WIDTH'(1);
                        if (pass_last) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_count == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops buffered beats and forgets outstanding reads so late returns are ignored.
        if (abort && ((state_q == RUN) || (state_q == DRAIN))) begin
            state_d    = DONE;
            issue_sr_d = '0;
            flush      = 1'b1;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            num_passes_q <= '0;
            pass_q       <= '0;
            rom_addr_q   <= '0;
            issue_sr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_passes_q <= num_passes_d;
            pass_q       <= pass_d;
            rom_addr_q   <= rom_addr_d;
            issue_sr_q   <= issue_sr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    param_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_data  (rom_q),
        .pop        (pop),
        .head       (data_out),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign rom_addr       = rom_addr_q;
    assign rom_ce         = 1'b1;
    assign data_out_valid = fifo_valid;

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Scoreboard bench for param_rom_stream_ctrl with a 4-word ROM holding 0x10+k and 2-cycle latency.
module tb_param_rom_stream_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned OD = 4;
    localparam int unsigned RL = 2;
    localparam int unsigned FD = 3;
    localparam int unsigned PW = 8;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] num_passes;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;

    logic [DW-1:0] rom_s1, rom_s2;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] data_prev;
    logic          stall_prev;
    int            checks, errors, beats, done_cnt, ready_mode;

    param_rom_stream_ctrl #(
        .DATA_WIDTH  (DW),
        .OUT_DEPTH   (OD),
        .ROM_LATENCY (RL),
        .FIFO_DEPTH  (FD),
        .PASS_WIDTH  (PW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_passes     (num_passes),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .rom_q          (rom_q),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-stage ROM pipeline: word k holds 0x10 + k.
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_s1 <= DW'(16'h0010) + DW'(rom_addr);
            rom_s2 <= rom_s1;
        end
    end
    assign rom_q = rom_s2;

    // Ready pattern: 0 = held low, 1 = held high, otherwise random.
    initial begin
        data_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_out_ready = 1'b0;
                1:       data_out_ready = 1'b1;
                default: data_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_seq(input int np);
        for (int p = 0; p < np; p++) begin
            for (int k = 0; k < int'(OD); k++) begin
                exp_q.push_back(DW'(16'h0010) + DW'(k));
            end
        end
    endtask

    // Call at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic do_start(input int np, input bit accepted);
        if (accepted) push_seq(np);
        start      = 1'b1;
        num_passes = PW'(np);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while ((done_cnt == base) && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("done_once", 32'(done_cnt - base), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_first_valid(output int lat);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat = n;
            if (data_out_valid) break;
        end
    endtask

    // Output monitor: scoreboard compare on each handshake, stall stability, done bookkeeping.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (stall_prev) begin
                chk("hold_valid", 32'(data_out_valid), 32'd1);
                chk("hold_data", 32'(data_out), 32'(data_prev));
            end
            if (data_out_valid && data_out_ready) begin
                beats++;
                if (exp_q.size() == 0) chk("unexpected_beat_sb_size", 32'(exp_q.size()), 32'd1);
                else chk("beat", 32'(data_out), 32'(exp_q.pop_front()));
            end
            stall_prev = data_out_valid && !data_out_ready;
            data_prev  = data_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b0, lat, n;
        checks     = 0;
        errors     = 0;
        beats      = 0;
        done_cnt   = 0;
        ready_mode = 1;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_passes = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Single pass, ready high: latency and back-to-back beats.
        base = done_cnt;
        do_start(1, 1'b1);
        wait_first_valid(lat);
        chk("first_valid_lat", 32'(lat), 32'd3);
        for (int i = 1; i < int'(OD); i++) begin
            @(negedge clk);
            chk("no_bubble_1p", 32'(data_out_valid), 32'd1);
        end
        wait_done(base, 50);

        // Three passes, ready high: no gap at the pass wraps.
        base = done_cnt;
        do_start(3, 1'b1);
        wait_first_valid(lat);
        chk("first_valid_lat_3p", 32'(lat), 32'd3);
        chk("busy_streaming", 32'(busy), 32'd1);
        for (int i = 1; i < 3 * int'(OD); i++) begin
            @(negedge clk);
            chk("no_bubble_3p", 32'(data_out_valid), 32'd1);
        end
        wait_done(base, 50);

        // Two passes under random backpressure.
        base = done_cnt;
        b0   = beats;
        ready_mode = 2;
        do_start(2, 1'b1);
        wait_done(base, 300);
        chk("rand_beat_count", 32'(beats - b0), 32'd8);
        ready_mode = 1;

        // Ready held low: exactly FIFO_DEPTH reads go out, then issue stops.
        base = done_cnt;
        ready_mode = 0;
        do_start(1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_addr", 32'(rom_addr), 32'd3);
        chk("stall_valid", 32'(data_out_valid), 32'd1);
        chk("stall_head", 32'(data_out), 32'h10);
        ready_mode = 1;
        wait_done(base, 50);

        // Zero passes: immediate done, no beats.
        base = done_cnt;
        b0   = beats;
        do_start(0, 1'b0);
        @(negedge clk);
        chk("np0_done", 32'(done), 32'd1);
        chk("np0_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        wait_done(base, 20);
        chk("np0_beats", 32'(beats - b0), 32'd0);

        // Start while busy is ignored.
        base = done_cnt;
        b0   = beats;
        do_start(1, 1'b1);
        @(posedge clk);
        #2;
        do_start(5, 1'b0);
        wait_done(base, 50);
        chk("busy_start_beats", 32'(beats - b0), 32'd4);

        // Abort after two beats, then a clean restart.
        base = done_cnt;
        b0   = beats;
        do_start(1, 1'b1);
        n = 0;
        while ((beats < b0 + 2) && (n < 50)) begin
            @(posedge clk);
            #2;
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_valid", 32'(data_out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #2;
        chk("abort_one_done", 32'(done_cnt - base), 32'd1);
        base = done_cnt;
        do_start(1, 1'b1);
        wait_done(base, 50);

        // Reset mid-sequence.
        do_start(3, 1'b1);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_addr", 32'(rom_addr), 32'd0);
        chk("mrst_valid", 32'(data_out_valid), 32'd0);
        chk("mrst_data", 32'(data_out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Recovery after reset.
        base = done_cnt;
        do_start(2, 1'b1);
        wait_done(base, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
